tsmf_src_arbiter: RTL and testbench

//  Packet-atomic round-robin arbiter feeding tsmf_split's single TS input (ts_din/ts_din_en).
//  Up to N_SRC sources, each holding one complete 188-byte TS packet as PKT_WORDS x 32-bit words.

---
 rtl/tsmf_src_arbiter.sv | 177 +++++++++++++++++
 tb/tb_tsmf_src_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tsmf_src_arbiter.sv
// Packet-atomic round-robin arbiter: grants one source at a time, forwards one whole TS packet
// through a registered mux, then holds a minimum idle gap before arbitrating again.
module tsmf_src_arbiter #(
    parameter int N_SRC     = 4,
    parameter int PKT_WORDS = 47,
    parameter int GAP_CYC   = 10,
    parameter int START_TO  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRC-1:0]     src_enable,
    input  logic [N_SRC-1:0]     src_req,
    output logic [N_SRC-1:0]     src_gnt,
    input  logic [32*N_SRC-1:0]  src_din,
    input  logic [N_SRC-1:0]     src_din_en,
    output logic [31:0]          ts_din,
    output logic                 ts_din_en,
    output logic [2:0]           cur_src,
    output logic                 pkt_done,
    output logic                 err_timeout,
    output logic                 err_short,
    output logic [1:0]           state_dbg
);

    localparam int TW = $clog2(START_TO + 1);
    localparam int GW = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_XFER, S_GAP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    cur_q, cur_d;
    logic [2:0]    rr_q, rr_d, rr_next;
    logic [5:0]    word_cnt_q, word_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          fwd, done_d, to_d, short_d;
    logic          found;
    logic [2:0]    winner;
    logic          sel_en;
    logic [31:0]   sel_din;

    // Handshake: src_gnt is the ready; a word moves on every cycle src_din_en[cur] (valid)
    // is high while granted. Valid dropping mid-packet ends the transfer as short.
    always_comb begin
        sel_en  = 1'b0;
        sel_din = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (cur_q == 3'(i)) begin
                sel_en  = src_din_en[i];
                sel_din = src_din[32*i +: 32];
            end
        end
    end

    // Round-robin search starting at rr_q, wrapping at N_SRC-1.
    always_comb begin
        found  = 1'b0;
        winner = rr_q;
        for (int k = 0; k < N_SRC; k++) begin
            int cand;
            cand = int'(rr_q) + k;
            if (cand >= N_SRC) cand = cand - N_SRC;
            for (int i = 0; i < N_SRC; i++) begin
                if (!found && cand == i && src_req[i] && src_enable[i]) begin
                    found  = 1'b1;
                    winner = 3'(i);
                end
            end
        end
    end

    assign rr_next = (cur_q == 3'(N_SRC - 1)) ? 3'd0 : cur_q + 3'd1;

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        rr_d       = rr_q;
        word_cnt_d = word_cnt_q;
        timer_d    = timer_q;
        gap_d      = gap_q;
        fwd        = 1'b0;
        done_d     = 1'b0;
        to_d       = 1'b0;
        short_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                word_cnt_d = '0;
                timer_d    = '0;
                gap_d      = '0;
                if (found) begin
                    state_d = S_GRANT;
                    cur_d   = winner;
                end
            end
            S_GRANT: begin
                if (sel_en) begin
                    fwd        = 1'b1;
                    word_cnt_d = 6'd1;
                    if (PKT_WORDS == 1) begin
                        done_d  = 1'b1;
                        rr_d    = rr_next;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_XFER;
                    end
                end else if (timer_q == TW'(START_TO - 1)) begin
                    to_d    = 1'b1;
                    rr_d    = rr_next;
                    state_d = S_GAP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_XFER: begin
                if (sel_en) begin
                    fwd        = 1'b1;
                    word_cnt_d = word_cnt_q + 6'd1;
                    if (word_cnt_q >= 6'(PKT_WORDS - 1)) begin
                        done_d  = 1'b1;
                        rr_d    = rr_next;
                        state_d = S_GAP;
                    end
                end else begin
                    // Partial packet is left as is; downstream resyncs on the 0x47 sync byte.
                    short_d = 1'b1;
                    rr_d    = rr_next;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_CYC - 1)) state_d = S_IDLE;
                else                           gap_d   = gap_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            rr_q        <= '0;
            word_cnt_q  <= '0;
            timer_q     <= '0;
            gap_q       <= '0;
            ts_din      <= '0;
            ts_din_en   <= 1'b0;
            pkt_done    <= 1'b0;
            err_timeout <= 1'b0;
            err_short   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            rr_q        <= rr_d;
            word_cnt_q  <= word_cnt_d;
            timer_q     <= timer_d;
            gap_q       <= gap_d;
            ts_din      <= fwd ? sel_din : 32'd0;
            ts_din_en   <= fwd;
            pkt_done    <= done_d;
            err_timeout <= to_d;
            err_short   <= short_d;
        end
    end

    // Grant decodes straight from state so it drops with the state register, including on reset.
    always_comb begin
        src_gnt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if ((state_q == S_GRANT || state_q == S_XFER) && cur_q == 3'(i)) src_gnt[i] = 1'b1;
        end
    end

    assign cur_src   = cur_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_tsmf_src_arbiter.sv
// Directed bench for tsmf_src_arbiter: a table of packet transfers plus hand-written
// timeout and reset-mid-transfer sequences, checked against an expected-word queue.
`timescale 1ns/1ps
module tb_tsmf_src_arbiter;

    localparam int N_SRC     = 4;
    localparam int PKT_WORDS = 47;
    localparam int GAP_CYC   = 10;
    localparam int START_TO  = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [N_SRC-1:0]    src_enable = '0;
    logic [N_SRC-1:0]    src_req = '0;
    logic [N_SRC-1:0]    src_gnt;
    logic [32*N_SRC-1:0] src_din = '0;
    logic [N_SRC-1:0]    src_din_en = '0;
    logic [31:0]         ts_din;
    logic                ts_din_en;
    logic [2:0]          cur_src;
    logic                pkt_done;
    logic                err_timeout;
    logic                err_short;
    logic [1:0]          state_dbg;

    tsmf_src_arbiter #(
        .N_SRC(N_SRC), .PKT_WORDS(PKT_WORDS), .GAP_CYC(GAP_CYC), .START_TO(START_TO)
    ) dut (
        .clk(clk), .rst(rst), .src_enable(src_enable), .src_req(src_req), .src_gnt(src_gnt),
        .src_din(src_din), .src_din_en(src_din_en), .ts_din(ts_din), .ts_din_en(ts_din_en),
        .cur_src(cur_src), .pkt_done(pkt_done), .err_timeout(err_timeout),
        .err_short(err_short), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;
    int          n_done = 0, n_short = 0, n_to = 0;
    int          burst_len = 0, last_burst_len = 0, idle_run = 0;
    bit          seen_burst = 1'b0;

    typedef struct {
        logic [N_SRC-1:0] enable;
        logic [N_SRC-1:0] req;
        int               src;
        int               nwords;
    } vec_t;

    vec_t vecs[11];

    // Scoreboard: every output word against the expected queue, gaps, pulse alignment.
    always @(negedge clk) begin
        if (!rst) begin
            burst_len  = 0;
            idle_run   = 0;
            seen_burst = 1'b0;
        end else begin
            if (ts_din_en === 1'b1) begin
                if (burst_len == 0 && seen_burst) begin
                    checks++;
                    if (idle_run < GAP_CYC) begin
                        failures++;
                        $display("FAIL gap: idle=%0d required>=%0d", idle_run, GAP_CYC);
                    end
                end
                burst_len++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word: got %h expected none", ts_din);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (ts_din !== exp_w) begin
                        failures++;
                        $display("FAIL ts_din: got %h expected %h", ts_din, exp_w);
                    end
                end
            end else begin
                if (burst_len != 0) begin
                    last_burst_len = burst_len;
                    burst_len      = 0;
                    seen_burst     = 1'b1;
                    idle_run       = 0;
                end
                idle_run++;
                checks++;
                if (ts_din !== 32'h0) begin
                    failures++;
                    $display("FAIL ts_din_idle: got %h expected 00000000", ts_din);
                end
            end
            if (pkt_done === 1'b1) begin
                n_done++;
                checks++;
                if (!(ts_din_en === 1'b1 && burst_len == PKT_WORDS)) begin
                    failures++;
                    $display("FAIL pkt_done_align: en=%b burst=%0d expected en=1 burst=%0d",
                             ts_din_en, burst_len, PKT_WORDS);
                end
            end
            if (err_short === 1'b1)   n_short++;
            if (err_timeout === 1'b1) n_to++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_word(input int src, input int tag, input int k);
        logic [31:0] w;
        if (k == 0) w = 32'h4710_0100 ^ {4'(src), 12'(tag), 16'h0};
        else        w = {4'(src), 12'(tag), 16'(k)};
        return w;
    endfunction

    task automatic wait_gnt(output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (src_gnt == '0 && n < 60) begin
            step();
            n++;
        end
        checks++;
        if (src_gnt == '0) begin
            failures++;
            $display("FAIL gnt_wait: got no grant in 60 cycles expected a grant");
        end else begin
            ok = 1'b1;
        end
    endtask

    // Drive n words from src, with junk on every other source's data/en.
    task automatic drive_words(input int src, input int nwords, input int tag);
        logic [31:0] w;
        for (int k = 0; k < nwords; k++) begin
            w = mk_word(src, tag, k);
            exp_q.push_back(w);
            for (int j = 0; j < N_SRC; j++) begin
                src_din_en[j]      = 1'($urandom_range(0, 1));
                src_din[32*j +: 32] = $urandom;
            end
            src_din_en[src]        = 1'b1;
            src_din[32*src +: 32]  = w;
            step();
        end
        src_din_en = '0;
        src_din    = '0;
    endtask

    task automatic run_pkt(input int src, input int nwords, input int tag);
        bit ok;
        int d0, s0;
        wait_gnt(ok);
        if (!ok) return;
        check("gnt_onehot", 32'(src_gnt), 32'(1 << src));
        check("cur_src", 32'(cur_src), 32'(src));
        d0 = n_done;
        s0 = n_short;
        drive_words(src, nwords, tag);
        if (nwords == PKT_WORDS) begin
            // Extra word after the packet end must be dropped.
            src_din_en[src]       = 1'b1;
            src_din[32*src +: 32] = 32'hDEAD_BEEF;
            step();
            src_din_en = '0;
            src_din    = '0;
        end
        repeat (4) step();
        check("pkt_done_cnt", 32'(n_done - d0), (nwords == PKT_WORDS) ? 32'd1 : 32'd0);
        check("err_short_cnt", 32'(n_short - s0), (nwords < PKT_WORDS) ? 32'd1 : 32'd0);
        check("burst_len", 32'(last_burst_len), 32'(nwords));
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("gnt_released", 32'(src_gnt), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int gcyc, t0, d0, s0;

        vecs[0]  = '{4'b1111, 4'b0001, 0, PKT_WORDS};
        vecs[1]  = '{4'b1111, 4'b1111, 1, PKT_WORDS};
        vecs[2]  = '{4'b1111, 4'b1111, 2, PKT_WORDS};
        vecs[3]  = '{4'b1111, 4'b1111, 3, PKT_WORDS};
        vecs[4]  = '{4'b1111, 4'b1111, 0, PKT_WORDS};
        vecs[5]  = '{4'b1010, 4'b1111, 1, PKT_WORDS};
        vecs[6]  = '{4'b1010, 4'b1111, 3, PKT_WORDS};
        vecs[7]  = '{4'b1010, 4'b1111, 1, PKT_WORDS};
        vecs[8]  = '{4'b1010, 4'b1111, 3, PKT_WORDS};
        vecs[9]  = '{4'b1111, 4'b0010, 1, 20};
        vecs[10] = '{4'b1111, 4'b1111, 2, PKT_WORDS};

        // Reset state, sampled while reset is held with requests pending.
        src_enable = 4'b1111;
        src_req    = 4'b1111;
        repeat (3) step();
        check("rst_gnt", 32'(src_gnt), 32'd0);
        check("rst_en", 32'(ts_din_en), 32'd0);
        check("rst_din", ts_din, 32'd0);
        check("rst_cur", 32'(cur_src), 32'd0);
        check("rst_pulses", {29'd0, pkt_done, err_timeout, err_short}, 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        src_req = '0;
        rst     = 1'b1;
        repeat (2) step();

        for (int v = 0; v < 11; v++) begin
            src_enable = vecs[v].enable;
            src_req    = vecs[v].req;
            run_pkt(vecs[v].src, vecs[v].nwords, v);
        end

        // Timeout: source 2 granted but silent.
        src_enable = 4'b1111;
        src_req    = 4'b0100;
        t0         = n_to;
        wait_gnt(ok);
        if (ok) begin
            check("to_gnt", 32'(src_gnt), 32'b0100);
            gcyc = 0;
            while (src_gnt != '0 && gcyc < 40) begin
                gcyc++;
                step();
            end
            check("to_gnt_cycles", 32'(gcyc), 32'(START_TO));
            check("to_pulse", 32'(err_timeout), 32'd1);
            src_req = 4'b1111;
            step();
            check("to_cnt", 32'(n_to - t0), 32'd1);
            run_pkt(3, PKT_WORDS, 11);
        end

        // Reset mid-transfer at word 30, then a fresh packet must come from source 0.
        src_req = 4'b0001;
        wait_gnt(ok);
        if (ok) begin
            drive_words(0, 30, 12);
            check("pre_rst_en", 32'(ts_din_en), 32'd1);
            d0 = n_done;
            s0 = n_short;
            #2;
            rst = 1'b0;
            #1;
            check("arst_en", 32'(ts_din_en), 32'd0);
            check("arst_gnt", 32'(src_gnt), 32'd0);
            check("arst_din", ts_din, 32'd0);
            exp_q.delete();
            src_req = '0;
            repeat (3) step();
            check("arst_state", 32'(state_dbg), 32'd0);
            check("arst_cur", 32'(cur_src), 32'd0);
            rst = 1'b1;
            step();
            check("arst_no_pulses", 32'(n_done - d0 + n_short - s0), 32'd0);
            src_req = 4'b1111;
            run_pkt(0, PKT_WORDS, 13);
        end
        src_req = '0;
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
